// File: rtl/reorder_retire_unit.sv
// 2-wide in-order retirement buffer: tracks out-of-order completion and
// returns displaced physical registers to the renamer free list in program order.
module reorder_retire_unit #(
    parameter int NUM_P_REGS  = 64,
    parameter int ROB_ENTRIES = 16,
    localparam int PREG_W = $clog2(NUM_P_REGS),
    localparam int IDX_W  = $clog2(ROB_ENTRIES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              alloc0_en_i,
    input  logic [PREG_W-1:0] alloc0_old_dest_i,
    input  logic              alloc0_regwrite_i,
    input  logic              alloc1_en_i,
    input  logic [PREG_W-1:0] alloc1_old_dest_i,
    input  logic              alloc1_regwrite_i,
    output logic              alloc_ready_o,
    output logic [IDX_W-1:0]  alloc0_idx_o,
    output logic [IDX_W-1:0]  alloc1_idx_o,
    input  logic              complete0_en_i,
    input  logic [IDX_W-1:0]  complete0_idx_i,
    input  logic              complete1_en_i,
    input  logic [IDX_W-1:0]  complete1_idx_i,
    output logic              en_free_reg0_o,
    output logic [PREG_W-1:0] free_reg0_o,
    output logic              en_free_reg1_o,
    output logic [PREG_W-1:0] free_reg1_o,
    output logic [1:0]        retired_o,
    output logic [IDX_W:0]    count_o,
    output logic              empty_o
);
    localparam int CNT_W = IDX_W + 1;

    logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d, head_p1;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ROB_ENTRIES-1:0] valid_q, valid_d, done_q, done_d, rw_q, rw_d;
    logic [ROB_ENTRIES-1:0][PREG_W-1:0] od_q, od_d;

    logic              en0_q, en0_d, en1_q, en1_d;
    logic [PREG_W-1:0] fr0_q, fr0_d, fr1_q, fr1_d;
    logic [1:0]        ret_q, ret_d;

    logic acc0, acc1, r0, r1;

    always_comb begin
        alloc_ready_o = (count_q <= CNT_W'(ROB_ENTRIES - 2));
        acc0          = alloc0_en_i & alloc_ready_o;
        acc1          = alloc1_en_i & alloc_ready_o;
        alloc0_idx_o  = tail_q;
        alloc1_idx_o  = tail_q + IDX_W'(alloc0_en_i);
        head_p1       = head_q + IDX_W'(1);
        r0            = valid_q[head_q] & done_q[head_q];
        r1            = r0 & valid_q[head_p1] & done_q[head_p1];

        valid_d = valid_q;
        done_d  = done_q;
        rw_d    = rw_q;
        od_d    = od_q;

        // Only pre-edge valid entries complete, so a same-cycle allocation is ignored.
        if (complete0_en_i && valid_q[complete0_idx_i]) done_d[complete0_idx_i] = 1'b1;
        if (complete1_en_i && valid_q[complete1_idx_i]) done_d[complete1_idx_i] = 1'b1;

        if (r0) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
        end
        if (r1) begin
            valid_d[head_p1] = 1'b0;
            done_d[head_p1]  = 1'b0;
        end

        // Allocation never overlaps retiring slots: alloc_ready_o keeps two free.
        if (acc0) begin
            valid_d[alloc0_idx_o] = 1'b1;
            done_d[alloc0_idx_o]  = 1'b0;
            rw_d[alloc0_idx_o]    = alloc0_regwrite_i;
            od_d[alloc0_idx_o]    = alloc0_old_dest_i;
        end
        if (acc1) begin
            valid_d[alloc1_idx_o] = 1'b1;
            done_d[alloc1_idx_o]  = 1'b0;
            rw_d[alloc1_idx_o]    = alloc1_regwrite_i;
            od_d[alloc1_idx_o]    = alloc1_old_dest_i;
        end

        tail_d  = tail_q + IDX_W'(acc0) + IDX_W'(acc1);
        head_d  = head_q + IDX_W'(r0) + IDX_W'(r1);
        count_d = count_q + CNT_W'(acc0) + CNT_W'(acc1) - CNT_W'(r0) - CNT_W'(r1);

        en0_d = r0 & rw_q[head_q];
        fr0_d = en0_d ? od_q[head_q] : '0;
        en1_d = r1 & rw_q[head_p1];
        fr1_d = en1_d ? od_q[head_p1] : '0;
        ret_d = 2'(r0) + 2'(r1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
            rw_q    <= '0;
            od_q    <= '0;
            en0_q   <= 1'b0;
            en1_q   <= 1'b0;
            fr0_q   <= '0;
            fr1_q   <= '0;
            ret_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            rw_q    <= rw_d;
            od_q    <= od_d;
            en0_q   <= en0_d;
            en1_q   <= en1_d;
            fr0_q   <= fr0_d;
            fr1_q   <= fr1_d;
            ret_q   <= ret_d;
        end
    end

    assign en_free_reg0_o = en0_q;
    assign free_reg0_o    = fr0_q;
    assign en_free_reg1_o = en1_q;
    assign free_reg1_o    = fr1_q;
    assign retired_o      = ret_q;
    assign count_o        = count_q;
    assign empty_o        = (count_q == '0);

endmodule

// File: tb/tb_reorder_retire_unit.sv
// Directed bench for reorder_retire_unit: pair ordering, full, wrap, no-write head, mid-run reset.
module tb_reorder_retire_unit;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       alloc0_en_i, alloc0_regwrite_i, alloc1_en_i, alloc1_regwrite_i;
    logic [5:0] alloc0_old_dest_i, alloc1_old_dest_i;
    logic       alloc_ready_o;
    logic [3:0] alloc0_idx_o, alloc1_idx_o;
    logic       complete0_en_i, complete1_en_i;
    logic [3:0] complete0_idx_i, complete1_idx_i;
    logic       en_free_reg0_o, en_free_reg1_o;
    logic [5:0] free_reg0_o, free_reg1_o;
    logic [1:0] retired_o;
    logic [4:0] count_o;
    logic       empty_o;

    int checks = 0;
    int failures = 0;
    int nfree = 0;

    reorder_retire_unit dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alloc0_en_i(alloc0_en_i), .alloc0_old_dest_i(alloc0_old_dest_i),
        .alloc0_regwrite_i(alloc0_regwrite_i),
        .alloc1_en_i(alloc1_en_i), .alloc1_old_dest_i(alloc1_old_dest_i),
        .alloc1_regwrite_i(alloc1_regwrite_i),
        .alloc_ready_o(alloc_ready_o), .alloc0_idx_o(alloc0_idx_o), .alloc1_idx_o(alloc1_idx_o),
        .complete0_en_i(complete0_en_i), .complete0_idx_i(complete0_idx_i),
        .complete1_en_i(complete1_en_i), .complete1_idx_i(complete1_idx_i),
        .en_free_reg0_o(en_free_reg0_o), .free_reg0_o(free_reg0_o),
        .en_free_reg1_o(en_free_reg1_o), .free_reg1_o(free_reg1_o),
        .retired_o(retired_o), .count_o(count_o), .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr;
        alloc0_en_i = 1'b0; alloc0_regwrite_i = 1'b0; alloc0_old_dest_i = '0;
        alloc1_en_i = 1'b0; alloc1_regwrite_i = 1'b0; alloc1_old_dest_i = '0;
        complete0_en_i = 1'b0; complete0_idx_i = '0;
        complete1_en_i = 1'b0; complete1_idx_i = '0;
    endtask

    task automatic alloc_pair(input logic [5:0] od0, input logic rw0,
                              input logic [5:0] od1, input logic rw1);
        alloc0_en_i = 1'b1; alloc0_old_dest_i = od0; alloc0_regwrite_i = rw0;
        alloc1_en_i = 1'b1; alloc1_old_dest_i = od1; alloc1_regwrite_i = rw1;
    endtask

    task automatic pulse_reset;
        rst_i = 1'b1;
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        clr;
        // Reset observed before any clock edge.
        #2;
        chk("rst_en0", 32'(en_free_reg0_o), 32'd0);
        chk("rst_en1", 32'(en_free_reg1_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_ready", 32'(alloc_ready_o), 32'd1);
        rst_i = 1'b0;
        tick;

        // Pair order: younger completes first but must wait for head.
        alloc_pair(6'd5, 1'b1, 6'd9, 1'b1);
        #1;
        chk("pair_idx0", 32'(alloc0_idx_o), 32'd0);
        chk("pair_idx1", 32'(alloc1_idx_o), 32'd1);
        tick;
        clr; complete1_en_i = 1'b1; complete1_idx_i = 4'd1;
        tick;
        chk("pair_nofree_a", 32'(en_free_reg0_o), 32'd0);
        clr; complete0_en_i = 1'b1; complete0_idx_i = 4'd0;
        tick;
        chk("pair_nofree_b", 32'(retired_o), 32'd0);
        clr;
        tick;
        chk("pair_en0", 32'(en_free_reg0_o), 32'd1);
        chk("pair_fr0", 32'(free_reg0_o), 32'd5);
        chk("pair_en1", 32'(en_free_reg1_o), 32'd1);
        chk("pair_fr1", 32'(free_reg1_o), 32'd9);
        chk("pair_ret", 32'(retired_o), 32'd2);
        chk("pair_empty", 32'(empty_o), 32'd1);
        tick;
        chk("pair_pulse_ret", 32'(retired_o), 32'd0);
        chk("pair_pulse_en0", 32'(en_free_reg0_o), 32'd0);
        chk("pair_pulse_fr0", 32'(free_reg0_o), 32'd0);

        // Full: restart from index 0, fill with 8 pairs.
        pulse_reset;
        for (int j = 0; j < 8; j++) begin
            alloc_pair(6'(20 + 2 * j), 1'b1, 6'(21 + 2 * j), 1'b1);
            #1;
            if (j == 7) chk("full_ready_at14", 32'(alloc_ready_o), 32'd1);
            tick;
        end
        chk("full_count", 32'(count_o), 32'd16);
        chk("full_ready", 32'(alloc_ready_o), 32'd0);
        chk("full_idx", 32'(alloc0_idx_o), 32'd0);
        alloc_pair(6'd60, 1'b1, 6'd61, 1'b1);
        tick;
        chk("full_rej_count", 32'(count_o), 32'd16);
        chk("full_rej_idx", 32'(alloc0_idx_o), 32'd0);
        clr; complete0_en_i = 1'b1; complete0_idx_i = 4'd0;
        complete1_en_i = 1'b1; complete1_idx_i = 4'd1;
        tick;
        chk("full_count_pre", 32'(count_o), 32'd16);
        clr;
        tick;
        chk("full_count_post", 32'(count_o), 32'd14);
        chk("full_ready_post", 32'(alloc_ready_o), 32'd1);
        chk("full_fr0", 32'(free_reg0_o), 32'd20);
        chk("full_fr1", 32'(free_reg1_o), 32'd21);

        // Wrap: 40 singles alternating ports, each completed two cycles later.
        pulse_reset;
        for (int t = 0; t < 46; t++) begin
            clr;
            if (t < 40) begin
                if (t % 2 == 0) begin
                    alloc0_en_i = 1'b1; alloc0_old_dest_i = 6'(t); alloc0_regwrite_i = 1'b1;
                end else begin
                    alloc1_en_i = 1'b1; alloc1_old_dest_i = 6'(t); alloc1_regwrite_i = 1'b1;
                end
            end
            if (t >= 2 && t < 42) begin
                if ((t - 2) % 2 == 0) begin
                    complete0_en_i = 1'b1; complete0_idx_i = 4'((t - 2) % 16);
                end else begin
                    complete1_en_i = 1'b1; complete1_idx_i = 4'((t - 2) % 16);
                end
            end
            #1;
            if (t < 40) begin
                if (t % 2 == 0) chk("wrap_idx0", 32'(alloc0_idx_o), 32'(t % 16));
                else            chk("wrap_idx1", 32'(alloc1_idx_o), 32'(t % 16));
            end
            tick;
            if (en_free_reg0_o) begin
                chk("wrap_free0", 32'(free_reg0_o), 32'(nfree));
                nfree++;
            end
            if (en_free_reg1_o) begin
                chk("wrap_free1", 32'(free_reg1_o), 32'(nfree));
                nfree++;
            end
        end
        chk("wrap_total", 32'(nfree), 32'd40);
        chk("wrap_empty", 32'(empty_o), 32'd1);

        // No-write head: head has no preg to free, younger does.
        clr;
        alloc_pair(6'd7, 1'b0, 6'd12, 1'b1);
        #1;
        chk("nw_idx0", 32'(alloc0_idx_o), 32'd8);
        chk("nw_idx1", 32'(alloc1_idx_o), 32'd9);
        tick;
        clr; complete0_en_i = 1'b1; complete0_idx_i = 4'd8;
        complete1_en_i = 1'b1; complete1_idx_i = 4'd9;
        tick;
        clr;
        tick;
        chk("nw_en0", 32'(en_free_reg0_o), 32'd0);
        chk("nw_fr0", 32'(free_reg0_o), 32'd0);
        chk("nw_en1", 32'(en_free_reg1_o), 32'd1);
        chk("nw_fr1", 32'(free_reg1_o), 32'd12);
        chk("nw_ret", 32'(retired_o), 32'd2);

        // Reset mid-run: entries 10..15 discarded, stale completions free nothing.
        for (int j = 0; j < 3; j++) begin
            alloc_pair(6'(30 + j), 1'b1, 6'(40 + j), 1'b1);
            tick;
        end
        clr;
        chk("mr_count6", 32'(count_o), 32'd6);
        complete0_en_i = 1'b1; complete0_idx_i = 4'd10;
        complete1_en_i = 1'b1; complete1_idx_i = 4'd11;
        tick;
        rst_i = 1'b1;
        #1;
        chk("mr_count0", 32'(count_o), 32'd0);
        chk("mr_en0", 32'(en_free_reg0_o), 32'd0);
        chk("mr_en1", 32'(en_free_reg1_o), 32'd0);
        chk("mr_empty", 32'(empty_o), 32'd1);
        rst_i = 1'b0;
        tick;
        complete0_en_i = 1'b1; complete0_idx_i = 4'd12;
        tick;
        clr;
        tick;
        chk("mr_stale_en0", 32'(en_free_reg0_o), 32'd0);
        chk("mr_stale_en1", 32'(en_free_reg1_o), 32'd0);
        chk("mr_stale_ret", 32'(retired_o), 32'd0);
        chk("mr_stale_count", 32'(count_o), 32'd0);
        alloc_pair(6'd1, 1'b1, 6'd2, 1'b1);
        #1;
        chk("mr_new_idx", 32'(alloc0_idx_o), 32'd0);
        clr;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reorder_retire_unit.md
Name: reorder_retire_unit

Overview:
- 2-wide in-order retirement buffer for the dual-issue RISC-V pipeline.
- Accepts up to two renamed instructions per cycle in program order, records each one's displaced physical register (old_dest), tracks out-of-order completion, and retires up to two per cycle in order.
- Drives the register renamer's free-register inputs (en_free_reg0_i/free_reg0_i, en_free_reg1_i/free_reg1_i), returning pregs to the free list. It is the release end of the rename allocate/free interface.

Parameters:
- NUM_P_REGS, 64, physical register count; PREG_W = $clog2(NUM_P_REGS).
- ROB_ENTRIES, 16, buffer depth; power of 2, >= 4; IDX_W = $clog2(ROB_ENTRIES).

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- alloc0_en_i  in  1  allocate older instruction of dispatch pair.
- alloc0_old_dest_i  in  PREG_W  preg displaced by instruction 0.
- alloc0_regwrite_i  in  1  instruction 0 writes a register (old_dest meaningful).
- alloc1_en_i, alloc1_old_dest_i, alloc1_regwrite_i  in  1/PREG_W/1  same for younger instruction.
- alloc_ready_o  out  1  space for two allocations this cycle.
- alloc0_idx_o, alloc1_idx_o  out  IDX_W  ROB index assigned to each allocation this cycle.
- complete0_en_i, complete0_idx_i  in  1/IDX_W  execution-done report, port 0.
- complete1_en_i, complete1_idx_i  in  1/IDX_W  execution-done report, port 1.
- en_free_reg0_o, free_reg0_o  out  1/PREG_W  free older retired preg (to renamer en_free_reg0_i/free_reg0_i).
- en_free_reg1_o, free_reg1_o  out  1/PREG_W  free younger retired preg.
- retired_o  out  2  instructions retired last edge (0..2).
- count_o  out  IDX_W+1  occupied entries.
- empty_o  out  1  count_o == 0.

Behaviour:
- State:
  - head, tail: IDX_W pointers that wrap naturally mod ROB_ENTRIES.
  - count.
  - Per entry: valid, done, regwrite, old_dest.
- Reset (async, immediate, no clock needed):
  - head = tail = count = 0; all valid/done cleared.
  - en_free_reg*_o = 0, free_reg*_o = 0, retired_o = 0.
  - alloc_ready_o = 1, empty_o = 1.
  - Reset mid-operation discards entries without freeing; the renamer resets independently.
- alloc_ready_o = (count <= ROB_ENTRIES-2), combinational from registered count. Allocation requests while alloc_ready_o = 0 are ignored entirely.
- Allocation (compacted to tail):
  - alloc0_idx_o = tail.
  - alloc1_idx_o = tail + alloc0_en_i.
  - If only alloc1_en_i is set, instruction 1 takes tail.
  - At the edge, each new entry gets valid = 1, done = 0, regwrite, old_dest; tail advances by the number allocated.
- Completion:
  - At the edge, done is set for each complete*_en_i whose index holds a valid entry.
  - Completion of an invalid entry is ignored.
  - Both ports on the same index is idempotent.
  - Completing an entry in its own allocation cycle is illegal; the unit ignores it.
- Retirement, evaluated on pre-edge state:
  - r0 = valid & done at head.
  - r1 = r0 & valid & done at head+1.
  - Retired entries are invalidated; head advances by r0+r1.
- Free outputs are registered, valid the cycle after retirement:
  - en_free_reg0_o = r0 & regwrite[head]; free_reg0_o = old_dest[head].
  - en_free_reg1_o = r1 & regwrite[head+1]; free_reg1_o = old_dest[head+1].
  - retired_o = r0 + r1.
  - free_reg*_o is 0 when the corresponding enable is 0.
- Latencies: completion at edge N, retire at edge N+1, free outputs visible after N+1. Minimum allocate-to-free is 3 edges.
- Simultaneous events: alloc, complete and retire in one cycle are legal. count_next = count + allocs - retires.
- Full: count = ROB_ENTRIES-1 still rejects a pair, since alloc_ready_o = 0; no single-slot allocation.
- Empty: no retirement; outputs pulse for one cycle only, and enables deassert on non-retiring cycles.
- Out-of-order completion never retires out of order; the younger waits for head.

Test Plan:
- Reset: assert rst_i without clock -> en_free_reg0_o = en_free_reg1_o = 0, count_o = 0, empty_o = 1, alloc_ready_o = 1.
- Pair order:
  - Allocate old_dest 5, 9 (regwrite 1), giving idx 0, 1.
  - Complete idx 1 -> no free.
  - Complete idx 0 -> next cycle en_free_reg0_o = 1, free_reg0_o = 5, en_free_reg1_o = 1, free_reg1_o = 9, retired_o = 2.
- Full:
  - 8 dual allocations, none completed -> count_o = 16, alloc_ready_o = 0.
  - Further allocs change neither count_o nor alloc0_idx_o.
  - Complete idx 0, 1 -> count 14 after retire, alloc_ready_o = 1.
- Wrap: stream 40 instructions, old_dest = i mod 64, completing each 2 cycles after allocation -> frees appear in exact order 0..39 across pointer wrap.
- No-write head: alloc regwrite 0 (old_dest 7) plus regwrite 1 (old_dest 12), complete both -> en_free_reg0_o = 0, free_reg0_o = 0, en_free_reg1_o = 1, free_reg1_o = 12, retired_o = 2.
- Reset mid-run: with count_o = 6, pulse rst_i between edges -> count_o = 0 and enables 0 immediately; later completions of old indices produce no frees.
